mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage between the EX/MEM register and the mem_wb register.
- Takes the address and store data computed in EX and runs the load or store on the data-memory bus using a req/ack handshake.
- Aligns and sign-extends load data, then presents a registered result bundle that is wired directly to mem_wb's inputs.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width (alu_result bits [ADDR_W-1:0] drive dmem_addr)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when the optional feature is compiled in

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  EX/MEM bundle valid
- alu_result_in  in  32  effective address, or ALU result for non-memory ops
- store_data_in  in  32  store data (low bits used for byte/half)
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- mem_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_in  in  1  zero-extend loads when 1
- reg_write_addr_in  in  5  destination register
- reg_write_en_in  in  1  destination write enable
- stall_out  out  1  upstream must hold its bundle while 1
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; rdata valid in the same cycle
- dmem_rdata  in  32  read word
- out_valid  out  1  result bundle valid (one pulse per instruction)
- mem_data_out  out  32  aligned, extended load data (0 for non-loads)
- alu_result_out  out  32  alu_result_in passed through
- reg_write_addr_out  out  5  passed through
- reg_write_en_out  out  1  passed through; forced to 0 on a fault
- misaligned_out  out  1  alignment fault flag, qualified by out_valid

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE; every output goes to 0, including dmem_req and stall_out.
  - If reset arrives mid-access, the request is dropped with no completion, and a late dmem_ack is ignored.
- FSM states: IDLE, ACCESS.
- IDLE, rising edge, in_valid=1:
  - Non-memory op (both mem_read_in and mem_write_in are 0): register the bundle; out_valid=1 next cycle (latency 1).
  - Memory op, misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no bus request; next cycle out_valid=1, misaligned_out=1, reg_write_en_out=0, mem_data_out=0.
  - Memory op, aligned: latch the bundle and go to ACCESS. dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are registered and valid from the first ACCESS cycle.
- ACCESS:
  - stall_out=1; the bus outputs are held stable until the ack.
  - On the edge where dmem_ack=1: capture dmem_rdata, drop dmem_req, return to IDLE, and set out_valid=1 on the following cycle.
  - Latency is (cycles from request to ack) + 1. Zero-wait memory (ack in the first ACCESS cycle) gives 2 cycles.
- stall_out = (state==ACCESS). It is combinational from state, so it is 0 in IDLE, and a new bundle is accepted on the same edge that the previous result is presented.
- out_valid is high for exactly one cycle per accepted instruction; all other result outputs hold their values between pulses.
- in_valid=0 in IDLE: out_valid=0 next cycle; the other outputs hold.
- Both mem_read_in and mem_write_in set: the op is treated as a load; the write is ignored.
- Loads (lane selected by addr[1:0]):
  - Byte: rdata[8*addr[1:0]+:8].
  - Half: rdata[16*addr[1]+:16].
  - Sign-extend to 32 bits unless mem_unsigned_in=1.
- Stores:
  - Byte: wdata = {4{sd[7:0]}}, be = 4'b0001 << addr[1:0].
  - Half: wdata = {2{sd[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
  - mem_data_out=0 for stores.
- dmem_ack while in IDLE is ignored.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req, return to IDLE, and next cycle pulse out_valid with bus_error_out=1, reg_write_en_out=0, mem_data_out=0.
  - Adds an output port bus_error_out (1 bit, reset 0).
  - An ack arriving in the same cycle as the timeout wins: normal completion.
- Undefined: no counter and no bus_error_out port; ACCESS waits for ack indefinitely.

Test Plan:
- Reset with reset=0 while in ACCESS and dmem_req=1 -> dmem_req, stall_out and out_valid are 0 immediately; an ack pulsed after release produces no out_valid.
- Non-memory op alu_result_in=32'h5A5A5A5A, reg_write_addr_in=5'b10101, reg_write_en_in=1 -> one cycle later out_valid=1, alu_result_out=32'h5A5A5A5A, reg_write_addr_out=5'b10101, mem_data_out=0, stall_out never 1.
- Signed byte load, addr=32'h103, rdata=32'hA5A5A5A5, ack after 3 wait cycles -> dmem_addr=32'h100, stall_out high 4 cycles, mem_data_out=32'hFFFFFFA5; the same with mem_unsigned_in=1 gives 32'h000000A5.
- Half store, addr=32'h202, store_data_in=32'h0000BEEF -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=32'hBEEFBEEF, one out_valid after ack.
- Word load at addr=32'h301 -> no dmem_req; next cycle out_valid=1, misaligned_out=1, reg_write_en_out=0.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack held 0 -> req drops after 4 ACCESS cycles, then out_valid=1 with bus_error_out=1 and stall_out=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads and stores over a req/ack data-memory bus and presents an aligned result bundle.
// Optional bus watchdog compiled in with `define MEM_ACCESS_TIMEOUT_EN (adds bus_error_out).
module mem_access_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       store_data_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic [4:0]        reg_write_addr_in,
    input  logic              reg_write_en_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              out_valid,
    output logic [31:0]       mem_data_out,
    output logic [31:0]       alu_result_out,
    output logic [4:0]        reg_write_addr_out,
    output logic              reg_write_en_out,
    output logic              misaligned_out
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    output logic              bus_error_out
`endif
);

    if (ADDR_W < 3 || ADDR_W > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_access_stage: ADDR_W must be 3..32 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic        is_mem, misaligned, timeout;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, load_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Instruction fields held for the duration of a bus access
    logic [31:0] lat_alu;
    logic [4:0]  lat_rd;
    logic        lat_rd_en, lat_load, lat_unsigned;
    logic [1:0]  lat_size;

    assign stall_out = (state == ACCESS);

    always_comb begin
        is_mem     = mem_read_in | mem_write_in;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = store_data_in;
        case (mem_size_in)
            2'b00: begin
                be_calc    = 4'b0001 << alu_result_in[1:0];
                wdata_calc = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                misaligned = alu_result_in[0];
                be_calc    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{store_data_in[15:0]}};
            end
            default: misaligned = |alu_result_in[1:0];
        endcase
    end

    always_comb begin
        lane_b    = dmem_rdata[{lat_alu[1:0], 3'b000} +: 8];
        lane_h    = dmem_rdata[{lat_alu[1], 4'b0000} +: 16];
        load_data = dmem_rdata;
        case (lat_size)
            2'b00:   load_data = lat_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_data = lat_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = dmem_rdata;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;

    // Held at zero in IDLE so every access starts counting from 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else if (!dmem_ack)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    assign timeout = (state == ACCESS) && !dmem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && is_mem && !misaligned) state_nxt = ACCESS;
            ACCESS:  if (dmem_ack || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req           <= 1'b0;
            dmem_we            <= 1'b0;
            dmem_addr          <= '0;
            dmem_wdata         <= '0;
            dmem_be            <= '0;
            out_valid          <= 1'b0;
            mem_data_out       <= '0;
            alu_result_out     <= '0;
            reg_write_addr_out <= '0;
            reg_write_en_out   <= 1'b0;
            misaligned_out     <= 1'b0;
            lat_alu            <= '0;
            lat_rd             <= '0;
            lat_rd_en          <= 1'b0;
            lat_load           <= 1'b0;
            lat_unsigned       <= 1'b0;
            lat_size           <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            bus_error_out      <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && (!is_mem || misaligned)) begin
                    out_valid          <= 1'b1;
                    alu_result_out     <= alu_result_in;
                    reg_write_addr_out <= reg_write_addr_in;
                    reg_write_en_out   <= reg_write_en_in & ~is_mem;
                    misaligned_out     <= is_mem;
                    mem_data_out       <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    bus_error_out      <= 1'b0;
`endif
                end else if (in_valid) begin
                    dmem_req     <= 1'b1;
                    dmem_we      <= mem_write_in & ~mem_read_in;
                    dmem_addr    <= {alu_result_in[ADDR_W-1:2], 2'b00};
                    dmem_wdata   <= wdata_calc;
                    dmem_be      <= be_calc;
                    lat_alu      <= alu_result_in;
                    lat_rd       <= reg_write_addr_in;
                    lat_rd_en    <= reg_write_en_in;
                    lat_load     <= mem_read_in;
                    lat_unsigned <= mem_unsigned_in;
                    lat_size     <= mem_size_in;
                end
            end else if (dmem_ack || timeout) begin
                // An ack coinciding with the watchdog expiry still completes normally
                dmem_req           <= 1'b0;
                out_valid          <= 1'b1;
                alu_result_out     <= lat_alu;
                reg_write_addr_out <= lat_rd;
                reg_write_en_out   <= lat_rd_en & dmem_ack;
                misaligned_out     <= 1'b0;
                mem_data_out       <= (lat_load && dmem_ack) ? load_data : '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                bus_error_out      <= ~dmem_ack;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: randomized instructions, a responding memory model and an output monitor.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] store_data_in = '0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [1:0]  mem_size_in = '0;
    logic        mem_unsigned_in = 1'b0;
    logic [4:0]  reg_write_addr_in = '0;
    logic        reg_write_en_in = 1'b0;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        out_valid;
    logic [31:0] mem_data_out, alu_result_out;
    logic [4:0]  reg_write_addr_out;
    logic        reg_write_en_out, misaligned_out;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic        bus_error_out;
`endif

    mem_access_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
        .reg_write_addr_in(reg_write_addr_in), .reg_write_en_in(reg_write_en_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
        .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
        .reg_write_addr_out(reg_write_addr_out), .reg_write_en_out(reg_write_en_out),
        .misaligned_out(misaligned_out)
`ifdef MEM_ACCESS_TIMEOUT_EN
        , .bus_error_out(bus_error_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        v, rd, wr, uns, en;
        logic [1:0]  size;
        logic [31:0] a, sd, rdata;
        logic [4:0]  rda;
        int          w;
    } op_t;

    typedef struct {
        logic [31:0] alu, data;
        logic [4:0]  rd;
        logic        en, mis;
        int          at, stall;
    } res_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic        we;
        logic [3:0]  be;
        int          w;
    } bus_t;

    res_t sb[$];
    bus_t bq[$];

    function automatic op_t rand_op();
        op_t o;
        int  bytes;
        o.v     = ($urandom_range(0, 5) != 0);
        o.rd    = $urandom_range(0, 1) == 1;
        o.wr    = $urandom_range(0, 1) == 1;
        o.uns   = $urandom_range(0, 1) == 1;
        o.en    = $urandom_range(0, 1) == 1;
        o.size  = 2'($urandom_range(0, 3));
        o.a     = $urandom;
        o.sd    = $urandom;
        o.rdata = $urandom;
        o.rda   = 5'($urandom_range(0, 31));
        o.w     = $urandom_range(0, 4);
        bytes   = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
        if ($urandom_range(0, 2) != 0) o.a = o.a - (o.a % bytes);
        return o;
    endfunction

    // Reference model: expected result bundle and bus transaction from the instruction's meaning
    task automatic issue(input op_t o);
        res_t r;
        bus_t b;
        int   bytes, lat;
        logic mem, mis;
        logic [31:0] sh, mask, mult;
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        int   ext;
        in_valid          = o.v;
        alu_result_in     = o.a;
        store_data_in     = o.sd;
        mem_read_in       = o.rd;
        mem_write_in      = o.wr;
        mem_size_in       = o.size;
        mem_unsigned_in   = o.uns;
        reg_write_addr_in = o.rda;
        reg_write_en_in   = o.en;
        if (!o.v) return;
        bytes = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
        mem   = o.rd | o.wr;
        mis   = mem && ((o.a % bytes) != 0);
        lat   = (!mem || mis) ? 1 : o.w + 2;
        r.alu = o.a;
        r.rd  = o.rda;
        r.en  = o.en & ~mis;
        r.mis = mis;
        r.at  = cyc + lat;
        r.stall = lat - 1;
        r.data  = '0;
        if (o.rd && !mis) begin
            sh  = o.rdata >> (8 * (o.a % 4));
            s8  = sh[7:0];
            s16 = sh[15:0];
            if (bytes == 1)      begin ext = s8;  r.data = o.uns ? (sh & 32'hFF)   : 32'(ext); end
            else if (bytes == 2) begin ext = s16; r.data = o.uns ? (sh & 32'hFFFF) : 32'(ext); end
            else r.data = o.rdata;
        end
        sb.push_back(r);
        if (mem && !mis) begin
            mask    = 32'hFFFF_FFFF >> (32 - 8 * bytes);
            mult    = (bytes == 1) ? 32'h0101_0101 : (bytes == 2) ? 32'h0001_0001 : 32'h1;
            b.addr  = o.a & 32'hFFFF_FFFC;
            b.we    = o.wr & ~o.rd;
            b.be    = 4'(((1 << bytes) - 1) << (o.a % 4));
            b.wdata = (o.sd & mask) * mult;
            b.rdata = o.rdata;
            b.w     = o.w;
            bq.push_back(b);
        end
    endtask

    task automatic memory_responder();
        bus_t b;
        forever begin
            @(negedge clk);
            if (!dmem_req) begin
                dmem_ack   = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end else if (bq.size() == 0) begin
                chk("unexpected_req", dmem_req, 1'b0);
                dmem_ack = 1'b1;
            end else begin
                b = bq.pop_front();
                chk("bus_addr", dmem_addr, b.addr);
                chk("bus_we", dmem_we, b.we);
                if (b.we) begin
                    chk("bus_be", dmem_be, b.be);
                    chk("bus_wdata", dmem_wdata, b.wdata);
                end
                for (int i = 0; i < b.w; i++) begin
                    dmem_ack   = 1'b0;
                    dmem_rdata = $urandom;
                    @(negedge clk);
                    chk("bus_req_held", dmem_req, 1'b1);
                    chk("bus_addr_held", dmem_addr, b.addr);
                end
                dmem_ack   = 1'b1;
                dmem_rdata = b.rdata;
                @(negedge clk);
                dmem_ack = 1'b0;
                chk("bus_req_drop", dmem_req, 1'b0);
            end
        end
    endtask

    task automatic monitor();
        res_t r;
        int   stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (stall_out) stall_cnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    r = sb.pop_front();
                    chk("alu_result_out", alu_result_out, r.alu);
                    chk("reg_write_addr_out", reg_write_addr_out, r.rd);
                    chk("reg_write_en_out", reg_write_en_out, r.en);
                    chk("misaligned_out", misaligned_out, r.mis);
                    chk("mem_data_out", mem_data_out, r.data);
                    chk("latency_cycle", cyc, r.at);
                    chk("stall_cycles", stall_cnt, r.stall);
`ifdef MEM_ACCESS_TIMEOUT_EN
                    chk("bus_error_out", bus_error_out, 1'b0);
`endif
                end
                stall_cnt = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    op_t dir[5];
    op_t o;

    initial begin
        dir[0] = '{v:1, rd:0, wr:0, uns:0, en:1, size:2'd2, a:32'h5A5A5A5A, sd:32'h0, rdata:32'h0, rda:5'b10101, w:0};
        dir[1] = '{v:1, rd:1, wr:0, uns:0, en:1, size:2'd0, a:32'h103, sd:32'h0, rdata:32'hA5A5A5A5, rda:5'd3, w:3};
        dir[2] = '{v:1, rd:1, wr:0, uns:1, en:1, size:2'd0, a:32'h103, sd:32'h0, rdata:32'hA5A5A5A5, rda:5'd4, w:3};
        dir[3] = '{v:1, rd:0, wr:1, uns:0, en:0, size:2'd1, a:32'h202, sd:32'h0000BEEF, rdata:32'h0, rda:5'd0, w:1};
        dir[4] = '{v:1, rd:1, wr:0, uns:0, en:1, size:2'd2, a:32'h301, sd:32'h0, rdata:32'h0, rda:5'd7, w:0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_stall_out", stall_out, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_be", dmem_be, 4'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_mem_data_out", mem_data_out, 32'h0);
        chk("rst_alu_result_out", alu_result_out, 32'h0);
        chk("rst_reg_write_addr_out", reg_write_addr_out, 5'h0);
        chk("rst_reg_write_en_out", reg_write_en_out, 1'b0);
        chk("rst_misaligned_out", misaligned_out, 1'b0);
        reset = 1'b1;

        // Reset in the middle of an access, then a late ack that must be ignored
        @(negedge clk);
        in_valid = 1'b1; mem_read_in = 1'b1; mem_size_in = 2'd2; alu_result_in = 32'h400;
        reg_write_en_in = 1'b1; reg_write_addr_in = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_req_before", dmem_req, 1'b1);
        chk("midrst_stall_before", stall_out, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_req", dmem_req, 1'b0);
        chk("midrst_stall", stall_out, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_out_valid", out_valid, 1'b0);
            chk("late_ack_stall", stall_out, 1'b0);
            @(negedge clk);
        end

        fork
            memory_responder();
            monitor();
        join_none

        for (int idx = 0; idx < 305; ) begin
            @(negedge clk);
            if (!stall_out) begin
                o = (idx < 5) ? dir[idx] : rand_op();
                issue(o);
                idx++;
            end else begin
                // Inputs are don't-care while stalled; scramble them
                o = rand_op();
                in_valid = o.v; alu_result_in = o.a; mem_read_in = o.rd; mem_write_in = o.wr;
                mem_size_in = o.size; store_data_in = o.sd;
            end
        end
        @(negedge clk);
        while (stall_out) @(negedge clk);
        in_valid = 1'b0;

        for (int i = 0; i < 50 && (sb.size() != 0 || bq.size() != 0); i++) @(negedge clk);
        chk("drain_results_pending", sb.size(), 0);
        chk("drain_bus_pending", bq.size(), 0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
